// File: rtl/key_mux_debounce_pkg.sv
// Shared types and default constants for the keypad channel selector/debouncer.
package key_mux_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    TRACK  = 1'b1
  } state_e;

  localparam int DEF_N_CH   = 12;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_DB_CNT = 4;

  // Default keypad layout: channels 0-9 are digits
  localparam int CH_SHARP = 10;
  localparam int CH_STAR  = 11;

endpackage

// File: rtl/key_mux_debounce_if.sv
// Keypad-side bundle: raw key lines and select control in, clean level/pulse/status out.
interface key_mux_debounce_if
  import key_mux_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W
);

  logic [N_CH-1:0]  d_in;
  logic [SEL_W-1:0] sel_in;
  logic             sel_load;
  logic             d_out;
  logic             d_rise;
  logic             sel_err;
  logic             settled;

  modport master (
    output d_in, sel_in, sel_load,
    input  d_out, d_rise, sel_err, settled
  );

  modport slave (
    input  d_in, sel_in, sel_load,
    output d_out, d_rise, sel_err, settled
  );

endinterface

// File: rtl/key_mux_debounce_debounce.sv
// Single-bit stability counter: settles after a restart, then tracks level changes
// of the selected line and flags accepted rising edges.
module key_debounce
  import key_mux_pkg::*;
#(
  parameter int DB_CNT = DEF_DB_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_i,
  input  logic restart_i,
  input  logic track_i,
  output logic level_o,
  output logic rise_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(DB_CNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    done_o  = 1'b0;
    if (restart_i) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (!track_i) begin
      // Settling exit adopts the current level silently, so a channel switch never fakes a press
      if (cnt_q == LAST) begin
        level_d = s_i;
        cnt_d   = '0;
        done_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (s_i == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = s_i;
      cnt_d   = '0;
      rise_d  = s_i;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/key_mux_debounce.sv
// Keypad front end: synchronises all key lines, selects one by a registered index
// and debounces it into a clean level plus a one-cycle press pulse.
module key_mux_debounce
  import key_mux_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DB_CNT = DEF_DB_CNT
) (
  input logic clk,
  input logic rst_n,
  key_mux_debounce_if.slave bus
);

  localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [SEL_W-1:0] sel_q;
  logic             sel_err_q;
  state_e           state_q, state_d;
  logic             s;
  logic             track;
  logic             done;
  logic             level;
  logic             rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.d_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else if (bus.sel_load) begin
      sel_q     <= bus.sel_in;
      sel_err_q <= ({1'b0, bus.sel_in} >= N_CH_EXT);
    end
  end

  // Compare-based mux: an out-of-range index simply matches no channel and yields 0
  always_comb begin
    s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q == SEL_W'(i)) s = sync2_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.sel_load) begin
      state_d = SETTLE;
    end else if (state_q == SETTLE && done) begin
      state_d = TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SETTLE;
    else        state_q <= state_d;
  end

  assign track = (state_q == TRACK);

  key_debounce #(
    .DB_CNT(DB_CNT)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_i      (s),
    .restart_i(bus.sel_load),
    .track_i  (track),
    .level_o  (level),
    .rise_o   (rise),
    .done_o   (done)
  );

  assign bus.d_out   = level;
  assign bus.d_rise  = rise;
  assign bus.sel_err = sel_err_q;
  assign bus.settled = track;

endmodule

// File: tb/tb_key_mux_debounce.sv
// Directed bench for key_mux_debounce: per-cycle expected outputs go into a scoreboard
// queue and a monitor compares them one cycle later, just after each rising edge.
module tb_key_mux_debounce;
  import key_mux_pkg::*;

  localparam int N_CH   = 12;
  localparam int SEL_W  = 4;
  localparam int DB_CNT = 4;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_mux_debounce_if #(.N_CH(N_CH), .SEL_W(SEL_W)) bus ();

  key_mux_debounce #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W),
    .DB_CNT(DB_CNT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  vec_t             sb[$];
  int               nVectors     = 0;
  int               nMiscompares = 0;
  logic [N_CH-1:0]  curDin;
  logic [SEL_W-1:0] curSel;

  // One call = one clock: inputs change at the falling edge, expectation is for after the next rising edge
  task automatic applyStimulus(input string name, input logic rstn, input logic [N_CH-1:0] din,
                               input logic [SEL_W-1:0] sel, input logic load, input logic [3:0] exp);
    vec_t v;
    @(negedge clk);
    rst_n        = rstn;
    bus.d_in     = din;
    bus.sel_in   = sel;
    bus.sel_load = load;
    curDin       = din;
    curSel       = sel;
    v.name       = name;
    v.exp        = exp;
    sb.push_back(v);
  endtask

  task automatic hold(input string name, input int n, input logic [3:0] exp);
    repeat (n) applyStimulus(name, 1'b1, curDin, curSel, 1'b0, exp);
  endtask

  task automatic setDin(input string name, input logic [N_CH-1:0] din, input logic [3:0] exp);
    applyStimulus(name, 1'b1, din, curSel, 1'b0, exp);
  endtask

  task automatic loadSel(input string name, input logic [SEL_W-1:0] sel, input logic [3:0] exp);
    applyStimulus(name, 1'b1, curDin, sel, 1'b1, exp);
  endtask

  task automatic checkOutput(input vec_t v);
    logic [3:0] got;
    got = {bus.d_out, bus.d_rise, bus.sel_err, bus.settled};
    nVectors++;
    if (got !== v.exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got {d_out,d_rise,sel_err,settled}=%b, expected %b", v.name, got, v.exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  // Expected nibble is {d_out, d_rise, sel_err, settled}
  initial begin
    rst_n        = 1'b0;
    bus.d_in     = '0;
    bus.sel_in   = '0;
    bus.sel_load = 1'b0;
    curDin       = '0;
    curSel       = '0;

    applyStimulus("reset", 1'b0, '0, '0, 1'b0, 4'b0000);
    applyStimulus("reset", 1'b0, '0, '0, 1'b0, 4'b0000);
    hold("settle after reset", 3, 4'b0000);
    hold("track after reset", 7, 4'b0001);

    loadSel("load ch3", 4'd3, 4'b0000);
    hold("settle ch3", 3, 4'b0000);
    hold("settled ch3", 3, 4'b0001);
    setDin("ch3 rise", 12'h008, 4'b0001);
    hold("ch3 rise count", 4, 4'b0001);
    hold("ch3 rise accept", 1, 4'b1101);
    hold("ch3 held", 3, 4'b1001);

    setDin("ch3 fall", 12'h000, 4'b1001);
    hold("ch3 fall count", 4, 4'b1001);
    hold("ch3 fall accept", 1, 4'b0001);
    hold("ch3 low", 2, 4'b0001);
    setDin("ch3 glitch", 12'h008, 4'b0001);
    hold("ch3 glitch", 1, 4'b0001);
    setDin("ch3 glitch end", 12'h000, 4'b0001);
    hold("ch3 glitch rejected", 5, 4'b0001);
    setDin("unselected ch5", 12'h020, 4'b0001);
    hold("unselected ch5", 6, 4'b0001);
    setDin("unselected ch5 off", 12'h000, 4'b0001);
    hold("unselected ch5 off", 3, 4'b0001);

    setDin("ch7 high", 12'h080, 4'b0001);
    hold("ch7 high", 3, 4'b0001);
    loadSel("load ch7", 4'd7, 4'b0000);
    hold("settle ch7", 3, 4'b0000);
    hold("settled ch7 no rise", 1, 4'b1001);
    hold("ch7 held", 2, 4'b1001);

    applyStimulus("load idx12", 1'b1, 12'hFFF, 4'd12, 1'b1, 4'b0010);
    hold("settle idx12", 3, 4'b0010);
    hold("track idx12", 4, 4'b0011);
    loadSel("load ch11", 4'd11, 4'b0000);
    hold("settle ch11", 3, 4'b0000);
    hold("settled ch11", 1, 4'b1001);
    hold("ch11 held", 2, 4'b1001);
    setDin("ch11 fall", 12'h7FF, 4'b1001);
    hold("ch11 fall count", 4, 4'b1001);
    hold("ch11 fall accept", 2, 4'b0001);

    applyStimulus("load ch2", 1'b1, 12'h000, 4'd2, 1'b1, 4'b0000);
    hold("settle ch2", 3, 4'b0000);
    hold("settled ch2", 3, 4'b0001);
    setDin("ch2 rise", 12'h004, 4'b0001);
    hold("ch2 rise count", 4, 4'b0001);
    loadSel("load ch4 on accept", 4'd4, 4'b0000);
    hold("settle ch4", 3, 4'b0000);
    hold("settled ch4", 1, 4'b0001);

    setDin("ch4 rise", 12'h010, 4'b0001);
    hold("ch4 rise count", 4, 4'b0001);
    hold("ch4 rise accept", 1, 4'b1101);
    hold("ch4 held", 1, 4'b1001);
    setDin("ch4 fall", 12'h000, 4'b1001);
    hold("ch4 fall count", 2, 4'b1001);
    applyStimulus("reset mid-count", 1'b0, 12'h000, 4'd4, 1'b0, 4'b0000);
    hold("settle after mid reset", 3, 4'b0000);
    hold("track after mid reset", 3, 4'b0001);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
